// File: rtl/bp_cfg_responder.sv
// bp_cfg_responder
//   Configuration-register responder for one core. It accepts write and read
//   commands that are addressed to this core. Writes update a small register
//   file and bump a write counter. Reads return one response, which stays
//   valid until the consumer takes it with resp_yumi_i.
//
// Ports
//   clk_i, reset_i        clock, synchronous active-high reset
//   cfg_v_i / cfg_w_i     command valid / write (1) or read (0)
//   cfg_core_i            target core id, all-ones = broadcast
//   cfg_addr_i/cfg_data_i register address / write data
//   cfg_ready_o           command can be accepted this cycle
//   resp_v_o/resp_data_o  read response valid / data
//   resp_err_o            read hit an unmapped address
//   resp_yumi_i           consumer takes the response
//   freeze_o              register 0 bit 0
//   regs_o                flat view of all registers, reg i at [i*W +: W]
//
// States
//   e_ready | idle, accepting commands
//   e_resp  | holding a read response until resp_yumi_i

module bp_cfg_responder #(
    parameter int cfg_core_width_p = 8,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 32,
    parameter int core_id_p        = 0,
    parameter int num_regs_p       = 16
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   cfg_v_i,
    input  logic                                   cfg_w_i,
    input  logic [cfg_core_width_p-1:0]            cfg_core_i,
    input  logic [cfg_addr_width_p-1:0]            cfg_addr_i,
    input  logic [cfg_data_width_p-1:0]            cfg_data_i,
    output logic                                   cfg_ready_o,
    output logic                                   resp_v_o,
    output logic [cfg_data_width_p-1:0]            resp_data_o,
    output logic                                   resp_err_o,
    input  logic                                   resp_yumi_i,
    output logic                                   freeze_o,
    output logic [num_regs_p*cfg_data_width_p-1:0] regs_o
);

    typedef enum logic {e_ready, e_resp} state_e;

    localparam logic [cfg_core_width_p-1:0] core_id_lp  = cfg_core_width_p'(core_id_p);
    localparam logic [cfg_addr_width_p-1:0] num_regs_lp = cfg_addr_width_p'(num_regs_p);
    localparam logic [cfg_data_width_p-1:0] one_lp      = cfg_data_width_p'(1);

    state_e state_q, state_n;

    logic [cfg_data_width_p-1:0] regs_q [num_regs_p];
    logic [cfg_data_width_p-1:0] wr_cnt_q;
    logic [cfg_data_width_p-1:0] resp_data_q;
    logic                        resp_err_q;

    logic                        accept;
    logic                        core_hit;
    logic                        core_bcast;
    logic                        wr_en;
    logic                        rd_en;
    logic                        addr_in_range;
    logic [cfg_data_width_p-1:0] rd_data;
    logic                        rd_err;

    // Reset gates ready, so commands that arrive during reset are never accepted.
    assign cfg_ready_o   = (state_q == e_ready) && !reset_i;
    assign accept        = cfg_v_i && cfg_ready_o;
    assign core_bcast    = &cfg_core_i;
    assign core_hit      = (cfg_core_i == core_id_lp);
    assign wr_en         = accept && cfg_w_i && (core_hit || core_bcast);
    // A broadcast read has no single responder, so it is dropped.
    assign rd_en         = accept && !cfg_w_i && core_hit && !core_bcast;
    assign addr_in_range = (cfg_addr_i < num_regs_lp);

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        if (addr_in_range) begin
            for (int i = 0; i < num_regs_p; i++) begin
                if (cfg_addr_i == cfg_addr_width_p'(i)) begin
                    rd_data = regs_q[i];
                end
            end
        end else if (&cfg_addr_i) begin
            rd_data = wr_cnt_q;
        end else begin
            rd_err = 1'b1;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            e_ready: if (rd_en)       state_n = e_resp;
            e_resp:  if (resp_yumi_i) state_n = e_ready;
            default:                  state_n = e_ready;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_ready;
        end else begin
            state_q <= state_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < num_regs_p; i++) begin
                regs_q[i] <= (i == 0) ? one_lp : '0;
            end
            wr_cnt_q <= '0;
        end else if (wr_en && addr_in_range) begin
            for (int i = 0; i < num_regs_p; i++) begin
                if (cfg_addr_i == cfg_addr_width_p'(i)) begin
                    regs_q[i] <= cfg_data_i;
                end
            end
            wr_cnt_q <= wr_cnt_q + one_lp;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else if (rd_en) begin
            resp_data_q <= rd_data;
            resp_err_q  <= rd_err;
        end
    end

    // Response outputs are forced low outside e_resp and during reset, so a
    // stale captured value never leaks onto the bus.
    assign resp_v_o    = (state_q == e_resp) && !reset_i;
    assign resp_data_o = resp_v_o ? resp_data_q : '0;
    assign resp_err_o  = resp_v_o && resp_err_q;
    assign freeze_o    = regs_q[0][0];

    for (genvar g = 0; g < num_regs_p; g++) begin : g_regs_o
        assign regs_o[g*cfg_data_width_p +: cfg_data_width_p] = regs_q[g];
    end

endmodule

// File: tb/tb_bp_cfg_responder.sv
module tb_bp_cfg_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        v = 1'b0, w = 1'b0, yumi = 1'b0;
    logic [7:0]  core = '0;
    logic [15:0] addr = '0;
    logic [31:0] data = '0;

    logic        ready, resp_v, resp_err, freeze;
    logic [31:0] resp_data;
    logic [511:0] regs;

    bp_cfg_responder dut (
        .clk_i(clk), .reset_i(reset), .cfg_v_i(v), .cfg_w_i(w),
        .cfg_core_i(core), .cfg_addr_i(addr), .cfg_data_i(data),
        .cfg_ready_o(ready), .resp_v_o(resp_v), .resp_data_o(resp_data),
        .resp_err_o(resp_err), .resp_yumi_i(yumi), .freeze_o(freeze),
        .regs_o(regs)
    );

    // Narrow-data instance so the write counter can be wrapped in a few writes.
    logic        wv = 1'b0, ww = 1'b0, wyumi = 1'b0;
    logic [7:0]  wcore = '0;
    logic [15:0] waddr = '0;
    logic [3:0]  wdata = '0;
    logic        w_ready, w_resp_v, w_resp_err, w_freeze;
    logic [3:0]  w_resp_data;
    logic [63:0] w_regs;

    bp_cfg_responder #(.cfg_data_width_p(4)) dut_w (
        .clk_i(clk), .reset_i(reset), .cfg_v_i(wv), .cfg_w_i(ww),
        .cfg_core_i(wcore), .cfg_addr_i(waddr), .cfg_data_i(wdata),
        .cfg_ready_o(w_ready), .resp_v_o(w_resp_v), .resp_data_o(w_resp_data),
        .resp_err_o(w_resp_err), .resp_yumi_i(wyumi), .freeze_o(w_freeze),
        .regs_o(w_regs)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Behavioural model: register array, write count, one pending response.
    logic [31:0] m_regs [16];
    logic [31:0] m_cnt = '0;
    bit          m_pend = 1'b0;
    logic [31:0] m_data = '0;
    bit          m_err = 1'b0;
    bit          check_en = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) m_regs[i] = (i == 0) ? 32'd1 : 32'd0;
            m_cnt  = 0;
            m_pend = 0;
        end else if (m_pend) begin
            if (yumi) m_pend = 0;
        end else if (v) begin
            if (w && (core == 8'h00 || core == 8'hFF)) begin
                if (addr < 16) begin
                    m_regs[addr[3:0]] = data;
                    m_cnt = m_cnt + 1;
                end
            end else if (!w && core == 8'h00) begin
                m_pend = 1;
                if (addr < 16) begin
                    m_data = m_regs[addr[3:0]];
                    m_err  = 0;
                end else if (addr == 16'hFFFF) begin
                    m_data = m_cnt;
                    m_err  = 0;
                end else begin
                    m_data = 0;
                    m_err  = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            bit exp_v;
            exp_v = m_pend && !reset;
            chk("ready", {31'b0, ready}, {31'b0, !reset && !m_pend});
            chk("resp_v", {31'b0, resp_v}, {31'b0, exp_v});
            chk("resp_data", resp_data, exp_v ? m_data : 32'd0);
            chk("resp_err", {31'b0, resp_err}, {31'b0, exp_v && m_err});
            chk("freeze", {31'b0, freeze}, {31'b0, m_regs[0][0]});
            for (int i = 0; i < 16; i++)
                chk($sformatf("reg%0d", i), regs[i*32 +: 32], m_regs[i]);
        end
    end

    task automatic cmd(input bit wr, input logic [7:0] c, input logic [15:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        v = 1'b1; w = wr; core = c; addr = a; data = d;
        @(posedge clk); #1;
        v = 1'b0; w = 1'b0; core = '0; addr = '0; data = '0;
    endtask

    task automatic yumi_pulse();
        @(posedge clk); #1; yumi = 1'b1;
        @(posedge clk); #1; yumi = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [15:0] a, input logic [31:0] ed,
                          input bit ee, input int hold);
        cmd(1'b0, 8'h00, a, 32'd0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk({nm, "_v"}, {31'b0, resp_v}, 32'd1);
            chk({nm, "_data"}, resp_data, ed);
            chk({nm, "_err"}, {31'b0, resp_err}, {31'b0, ee});
        end
        yumi_pulse();
        @(negedge clk);
        chk({nm, "_ready_after"}, {31'b0, ready}, 32'd1);
        chk({nm, "_v_after"}, {31'b0, resp_v}, 32'd0);
    endtask

    task automatic wcmd(input bit wr, input logic [15:0] a, input logic [3:0] d);
        @(posedge clk); #1;
        wv = 1'b1; ww = wr; waddr = a; wdata = d;
        @(posedge clk); #1;
        wv = 1'b0; ww = 1'b0; waddr = '0; wdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset behaviour, commands during reset ignored
        @(posedge clk); #1;
        check_en = 1'b1;
        v = 1'b1; w = 1'b1; core = 8'h00; addr = 16'd0; data = 32'd0;
        @(negedge clk);
        chk("rst_freeze", {31'b0, freeze}, 32'd1);
        chk("rst_reg0", regs[31:0], 32'd1);
        chk("rst_reg7", regs[7*32 +: 32], 32'd0);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("w_rst_freeze", {31'b0, w_freeze}, 32'd1);
        chk("w_rst_reg0", {28'b0, w_regs[3:0]}, 32'd1);
        @(posedge clk); #1;
        v = 1'b0; w = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_freeze", {31'b0, freeze}, 32'd1);
        chk("post_rst_ready", {31'b0, ready}, 32'd1);

        // clear freeze
        cmd(1'b1, 8'h00, 16'd0, 32'd0);
        @(negedge clk);
        chk("unfreeze", {31'b0, freeze}, 32'd0);

        // write then read back with held response
        cmd(1'b1, 8'h00, 16'd3, 32'hA5A5A5A5);
        rd_chk("rd3", 16'd3, 32'hA5A5A5A5, 1'b0, 5);

        // other core dropped, broadcast write, broadcast read dropped
        cmd(1'b1, 8'h05, 16'd4, 32'h00001234);
        cmd(1'b1, 8'hFF, 16'd2, 32'd7);
        @(negedge clk);
        chk("core5_reg4", regs[4*32 +: 32], 32'd0);
        chk("bcast_reg2", regs[2*32 +: 32], 32'd7);
        cmd(1'b0, 8'hFF, 16'd3, 32'd0);
        @(negedge clk);
        chk("bcast_rd_v", {31'b0, resp_v}, 32'd0);
        chk("bcast_rd_ready", {31'b0, ready}, 32'd1);
        cmd(1'b0, 8'h05, 16'd3, 32'd0);
        @(negedge clk);
        chk("core5_rd_v", {31'b0, resp_v}, 32'd0);

        // unmapped address
        rd_chk("rd100", 16'h0100, 32'd0, 1'b1, 2);
        cmd(1'b1, 8'h00, 16'h0100, 32'hDEADBEEF);
        rd_chk("cnt_a", 16'hFFFF, 32'd3, 1'b0, 1);

        // counter after fresh reset, boundary addresses 15 and 16
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        cmd(1'b1, 8'h00, 16'd1, 32'h11111111);
        cmd(1'b1, 8'h00, 16'd5, 32'h55555555);
        cmd(1'b1, 8'h00, 16'd15, 32'hF0F0F0F0);
        cmd(1'b1, 8'h00, 16'd16, 32'h16161616);
        rd_chk("cnt_b", 16'hFFFF, 32'd3, 1'b0, 1);
        rd_chk("rd15", 16'd15, 32'hF0F0F0F0, 1'b0, 1);
        rd_chk("rd16", 16'd16, 32'd0, 1'b1, 1);

        // reset while a response is pending
        cmd(1'b0, 8'h00, 16'd5, 32'd0);
        @(negedge clk);
        chk("pend_v", {31'b0, resp_v}, 32'd1);
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        chk("rst_in_resp_v", {31'b0, resp_v}, 32'd0);
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        chk("rst_in_resp_ready", {31'b0, ready}, 32'd1);
        chk("rst_in_resp_v2", {31'b0, resp_v}, 32'd0);

        // counter wrap on the 4-bit instance
        for (int k = 1; k <= 15; k++) wcmd(1'b1, 16'd1, 4'(k));
        wcmd(1'b0, 16'hFFFF, 4'd0);
        @(negedge clk);
        chk("wcnt_full_v", {31'b0, w_resp_v}, 32'd1);
        chk("wcnt_full", {28'b0, w_resp_data}, 32'h0000000F);
        chk("wcnt_full_err", {31'b0, w_resp_err}, 32'd0);
        chk("wcnt_ready_busy", {31'b0, w_ready}, 32'd0);
        @(posedge clk); #1; wyumi = 1'b1;
        @(posedge clk); #1; wyumi = 1'b0;
        wcmd(1'b1, 16'd2, 4'd9);
        @(negedge clk);
        chk("w_reg2", {28'b0, w_regs[8 +: 4]}, 32'd9);
        wcmd(1'b0, 16'hFFFF, 4'd0);
        @(negedge clk);
        chk("wcnt_wrap_v", {31'b0, w_resp_v}, 32'd1);
        chk("wcnt_wrap", {28'b0, w_resp_data}, 32'd0);
        @(posedge clk); #1; wyumi = 1'b1;
        @(posedge clk); #1; wyumi = 1'b0;

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
